instr_encoder: RTL
==================

Name: instr_encoder

Overview:
Inverse of the core's immediate generator. Takes decoded instruction fields plus a 32-bit signed immediate and emits the packed RV32I instruction word, with the immediate bits scattered into R/I/S/B/U/J positions.
Used by the test-program loader to build instruction-memory images in hardware. Checks that the immediate is in range, buffers results in a 2-entry output FIFO with valid/ready on both sides, and tags each emitted word with a sequential word address.

Parameters:
DATA_WIDTH, 32, instruction/immediate width (only 32 supported)
ADDR_WIDTH, 8, width of emitted word-address counter
FIFO_DEPTH, 2, output buffer entries (power of two, >=2)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid & in_ready
fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J, 6..7 illegal
opcode  input  7  instr[6:0]
rd  input  5  destination register
funct3  input  3  funct3 field
rs1  input  5  source 1
rs2  input  5  source 2
funct7  input  7  R-type only
imm  input  DATA_WIDTH  signed byte offset / value (U: full upper value)
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer ready
out_instr  output  DATA_WIDTH  packed instruction
out_addr  output  ADDR_WIDTH  word address of out_instr
addr_clr  input  1  sync clear of address counter and error state
err_range  output  1  sticky: a request was dropped
err_cnt  output  8  count of dropped requests, saturates at 255

Behaviour:
- Reset (rst_n low, async): FIFO empty, out_valid=0, out_instr=0, out_addr=0, err_range=0, err_cnt=0, address counter=0. Reset mid-transfer discards all FIFO contents.
- in_ready = (FIFO count < FIFO_DEPTH); combinational from registered count only, never from in_valid.
- Packing (combinational, registered into FIFO on accept):
  R: funct7|rs2|rs1|f3|rd|op
  I: imm[11:0]|rs1|f3|rd|op
  S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  U: imm[31:12]|rd|op
  J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Legality: I/S need imm in [-2048,2047]. B needs imm in [-4096,4094] with imm[0]=0. J needs imm in [-2^20, 2^20-2] with imm[0]=0. U needs imm[11:0]=0. R ignores imm. fmt 6/7 is always illegal.
- Illegal accepted request: handshake still completes, nothing pushed, err_range<=1, err_cnt<=err_cnt+1 (saturating), address counter unchanged.
- Legal accepted request: pushed with tag = current address counter; counter increments, wrapping 2^ADDR_WIDTH-1 -> 0.
- Latency: accept at edge N into empty FIFO -> out_valid=1 after edge N, same cycle out_instr is valid.
- Pop on out_valid & out_ready. Simultaneous push and pop in the same cycle keeps count constant. Strict FIFO order.
- out_instr/out_addr hold stable while out_valid & !out_ready.
- addr_clr: next edge sets counter=0, err_range=0, err_cnt=0. FIFO contents and their tags are untouched. If addr_clr coincides with a legal accept, the accepted word gets tag 0 and the counter becomes 1. If it coincides with an illegal accept, the clear wins: err_cnt=0.

Decomposition:
- Shared package riscv_pkg: fmt_e enum (FMT_R..FMT_J), opcode constants, IMM range constants.
- Sub-module sync_fifo: parameterised width/depth, push/pop/count.
- Packing and range check stay in instr_encoder as always_comb.

Test Plan:
- I: op=0010011 rd=1 f3=0 rs1=0 imm=-1 -> out_instr=0xFFF00093, out_addr=0.
- S then B: sw op=0100011 f3=2 rs1=1 rs2=2 imm=-8 -> 0xFE20AC23 @addr0. beq op=1100011 rs1=rs2=0 imm=-4 -> 0xFE000EE3 @addr1.
- U/J: lui rd=5 imm=0x12345000 -> 0x123452B7. jal rd=1 imm=2048 -> 0x001000EF. Addresses consecutive.
- Range: I imm=2048, then B imm=3 -> both dropped, err_range=1, err_cnt=2, no out_valid. Next legal word gets the unchanged address.
- Backpressure: out_ready=0, offer 3 legal words -> in_ready=0 after 2 accepted. Release out_ready -> words emerge in order with addrs 0,1,2.
- Wrap/reset: ADDR_WIDTH=2, emit 5 words -> addrs 0,1,2,3,0. Assert rst_n=0 with FIFO full -> out_valid=0 immediately, counters 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding definitions: instruction formats, opcodes and immediate limits.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

  function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle between the program loader and the instruction encoder.
interface instr_encoder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            fmt;
  logic [6:0]            opcode;
  logic [4:0]            rd;
  logic [2:0]            funct3;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [6:0]            funct7;
  logic [DATA_WIDTH-1:0] imm;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  addr_clr;
  logic                  err_range;
  logic [7:0]            err_cnt;

  modport master (
    output in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready, addr_clr,
    input  in_ready, out_valid, out_instr, out_addr, err_range, err_cnt
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready, addr_clr,
    output in_ready, out_valid, out_instr, out_addr, err_range, err_cnt
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; the caller guarantees no push when full and no pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_mem[r_wptr] <= wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (pop) r_rptr <= r_rptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rptr];
  assign count = r_count;

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields plus a signed immediate into an instruction word,
// drops out-of-range requests, and queues legal words tagged with a word address.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 2
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0]        w_word;
  logic                         w_legal;
  logic                         w_accept;
  logic                         w_push;
  logic                         w_pop;
  logic [CW-1:0]                w_count;
  logic [ADDR_WIDTH-1:0]        w_tag;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] w_head;
  logic signed [DATA_WIDTH-1:0] w_imm;
  logic [ADDR_WIDTH-1:0]        r_addr;
  logic                         r_err;
  logic [7:0]                   r_cnt;

  assign w_imm = bus.imm;

  always_comb begin
    w_word  = '0;
    w_legal = 1'b0;
    case (fmt_e'(bus.fmt))
      FMT_R: begin
        w_word  = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
        w_legal = 1'b1;
      end
      FMT_I: begin
        w_word  = {w_imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        w_legal = in_range(w_imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        w_word  = {w_imm[11:5], bus.rs2, bus.rs1, bus.funct3, w_imm[4:0], bus.opcode};
        w_legal = in_range(w_imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        w_word  = {w_imm[12], w_imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                   w_imm[4:1], w_imm[11], bus.opcode};
        w_legal = in_range(w_imm, IMM13_MIN, IMM13_MAX) && !w_imm[0];
      end
      FMT_U: begin
        w_word  = {w_imm[31:12], bus.rd, bus.opcode};
        w_legal = (w_imm[11:0] == 12'd0);
      end
      FMT_J: begin
        w_word  = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.rd, bus.opcode};
        w_legal = in_range(w_imm, IMM21_MIN, IMM21_MAX) && !w_imm[0];
      end
      default: begin
        w_word  = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  // Ready depends only on the registered occupancy, never on in_valid.
  assign bus.in_ready = (w_count < FULL_CNT);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_push       = w_accept && w_legal;
  assign w_pop        = bus.out_valid && bus.out_ready;
  assign w_tag        = bus.addr_clr ? '0 : r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else if (bus.addr_clr) begin
      r_addr <= {{(ADDR_WIDTH-1){1'b0}}, w_push};
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_push) begin
      r_addr <= r_addr + 1'b1;
    end else if (w_accept) begin
      r_err <= 1'b1;
      if (r_cnt != 8'hFF) r_cnt <= r_cnt + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + ADDR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({w_tag, w_word}),
    .rdata (w_head),
    .count (w_count)
  );

  assign bus.out_valid = (w_count != '0);
  assign bus.out_instr = w_head[DATA_WIDTH-1:0];
  assign bus.out_addr  = w_head[DATA_WIDTH +: ADDR_WIDTH];
  assign bus.err_range = r_err;
  assign bus.err_cnt   = r_cnt;

endmodule
